r_chan_fifo_arbiter: RTL

Single-clock controller and 2:1 arbiter for the AXI read-data (R) FIFO memory.
- Two R-channel sources (slave side) share the memory's write port; one consumer (master side) drains the read port.
- Owns the write/read pointers, full/empty generation and round-robin burst-locked arbitration, so beats of one burst are never interleaved with another source's beats.

---
 rtl/r_chan_fifo_arbiter_if.sv | 44 ++++
 rtl/r_chan_fifo_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/r_chan_fifo_arbiter_if.sv
// R-channel FIFO arbiter bus: two R sources, FIFO memory port, consumer.
// slave = arbiter side, master = environment side (sources, memory, sink).
interface r_chan_fifo_arbiter_if #(
    parameter int DATASIZE = 43,
    parameter int ADDRSIZE = 2
);
    logic                s0_valid;
    logic [DATASIZE-1:0] s0_data;
    logic                s0_last;
    logic                s0_ready;
    logic                s1_valid;
    logic [DATASIZE-1:0] s1_data;
    logic                s1_last;
    logic                s1_ready;
    logic [DATASIZE-1:0] mem_wdata;
    logic [ADDRSIZE-1:0] mem_waddr;
    logic                mem_wpush;
    logic                mem_wfull;
    logic [ADDRSIZE-1:0] mem_raddr;
    logic [DATASIZE-1:0] mem_rdata;
    logic                m_valid;
    logic [DATASIZE-1:0] m_data;
    logic                m_ready;
    logic [ADDRSIZE:0]   count;
    logic [1:0]          owner;

    modport slave (
        input  s0_valid, s0_data, s0_last,
        input  s1_valid, s1_data, s1_last,
        input  mem_rdata, m_ready,
        output s0_ready, s1_ready,
        output mem_wdata, mem_waddr, mem_wpush, mem_wfull, mem_raddr,
        output m_valid, m_data, count, owner
    );

    modport master (
        output s0_valid, s0_data, s0_last,
        output s1_valid, s1_data, s1_last,
        output mem_rdata, m_ready,
        input  s0_ready, s1_ready,
        input  mem_wdata, mem_waddr, mem_wpush, mem_wfull, mem_raddr,
        input  m_valid, m_data, count, owner
    );
endinterface

// File: rtl/r_chan_fifo_arbiter.sv
// 2:1 burst-locked round-robin arbiter and pointer controller for the R FIFO.
// Ports: clk, rst (sync, active-high), bus (slave modport: sources, memory, sink).
module r_chan_fifo_arbiter #(
    parameter int DATASIZE = 43,
    parameter int ADDRSIZE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    r_chan_fifo_arbiter_if.slave   bus
);
    localparam int A = ADDRSIZE;
    localparam logic [A:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t      state;
    logic        rr;
    logic [1:0]  owner_q;
    logic [A:0]  wptr;
    logic [A:0]  rptr;

    logic full;
    logic empty;
    logic gnt0;
    logic gnt1;
    logic rdy0;
    logic rdy1;
    logic push;
    logic pop;
    logic last;

    assign empty = (wptr == rptr);
    assign full  = (wptr[A] != rptr[A]) && (wptr[A-1:0] == rptr[A-1:0]);

    // Grant: locked source only, else preferred (rr) source first.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state)
            IDLE: begin
                if (rr) begin
                    gnt1 = bus.s1_valid;
                    gnt0 = bus.s0_valid & ~bus.s1_valid;
                end else begin
                    gnt0 = bus.s0_valid;
                    gnt1 = bus.s1_valid & ~bus.s0_valid;
                end
            end
            LOCK0:   gnt0 = 1'b1;
            LOCK1:   gnt1 = 1'b1;
            default: ;
        endcase
    end

    // No pop-to-push bypass: full blocks even when a pop is under way.
    assign rdy0 = gnt0 & ~full & ~rst;
    assign rdy1 = gnt1 & ~full & ~rst;
    assign push = (bus.s0_valid & rdy0) | (bus.s1_valid & rdy1);
    assign pop  = ~empty & bus.m_ready;
    assign last = gnt1 ? bus.s1_last : bus.s0_last;

    assign bus.s0_ready  = rdy0;
    assign bus.s1_ready  = rdy1;
    assign bus.mem_wdata = gnt1 ? bus.s1_data : bus.s0_data;
    assign bus.mem_waddr = wptr[A-1:0];
    assign bus.mem_wpush = push;
    assign bus.mem_wfull = full;
    assign bus.mem_raddr = rptr[A-1:0];
    assign bus.m_valid   = ~empty;
    assign bus.m_data    = bus.mem_rdata;
    assign bus.count     = wptr - rptr;
    assign bus.owner     = owner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            state   <= IDLE;
            rr      <= 1'b0;
            owner_q <= 2'b00;
        end else begin
            if (push) wptr <= wptr + ONE;
            if (pop)  rptr <= rptr + ONE;
            if (push && last) begin
                // Burst complete: hand preference to the other source.
                state   <= IDLE;
                rr      <= ~gnt1;
                owner_q <= 2'b00;
            end else if (push && state == IDLE) begin
                state   <= gnt1 ? LOCK1 : LOCK0;
                owner_q <= gnt1 ? 2'b10 : 2'b01;
            end
        end
    end
endmodule
